camera_pose_scheduler: RTL and testbench

Per-frame controller for the view-basis datapath (`view_output_simple`). It samples user steering buttons once per frame and updates pitch/yaw/roll with clamp and wrap rules. It then starts one basis computation and waits for its completion. It commits the resulting forward/up/right vectors to a frame-stable output bank, so the renderer never sees a half-updated camera.

---
 rtl/camera_pkg.sv | 56 +++++
 rtl/angle_stepper.sv | 57 +++++
 rtl/camera_pose_scheduler.sv | 131 +++++++++++++
 tb/tb_camera_pose_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_pkg.sv
// Shared types and constants for the camera pose scheduler: basis vectors,
// FSM state encoding, button bit positions and axis update modes.
package camera_pkg;

    localparam int CAM_FRAC_BITS = 16;
    localparam logic signed [31:0] ONE = 32'sd1 <<< CAM_FRAC_BITS;

    typedef struct packed {
        logic signed [31:0] x;
        logic signed [31:0] y;
        logic signed [31:0] z;
    } vec3_t;

    // Unit vector along axis 0=x, 1=y, 2=z with the given fixed-point scale.
    function automatic vec3_t ident_vec(input int axis, input int frac_bits);
        vec3_t v;
        v = '0;
        case (axis)
            0:       v.x = 32'sd1 <<< frac_bits;
            1:       v.y = 32'sd1 <<< frac_bits;
            default: v.z = 32'sd1 <<< frac_bits;
        endcase
        return v;
    endfunction

    localparam vec3_t ID_FWD   = ident_vec(2, CAM_FRAC_BITS);
    localparam vec3_t ID_UP    = ident_vec(1, CAM_FRAC_BITS);
    localparam vec3_t ID_RIGHT = ident_vec(0, CAM_FRAC_BITS);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_STEP   = 3'd1;
    localparam logic [2:0] ST_REQ    = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_COMMIT = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_STEP   = ST_STEP,
        S_REQ    = ST_REQ,
        S_WAIT   = ST_WAIT,
        S_COMMIT = ST_COMMIT
    } state_t;

    localparam int BTN_PITCH_UP   = 0;
    localparam int BTN_PITCH_DOWN = 1;
    localparam int BTN_YAW_RIGHT  = 2;
    localparam int BTN_YAW_LEFT   = 3;
    localparam int BTN_ROLL_CW    = 4;
    localparam int BTN_ROLL_CCW   = 5;

    typedef enum logic {
        MODE_CLAMP = 1'b0,
        MODE_WRAP  = 1'b1
    } axis_mode_t;

endpackage

// File: rtl/angle_stepper.sv
// One steering axis: adds or subtracts STEP degrees when enabled, then either
// saturates to +/-LIMIT (clamp) or wraps into 0..359 (wrap).
module angle_stepper
    import camera_pkg::*;
#(
    parameter int STEP  = 2,
    parameter int LIMIT = 80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       inc,
    input  logic       dec,
    input  axis_mode_t mode,
    output logic [8:0] angle
);

    localparam logic signed [9:0] STEP_S = 10'(STEP);
    localparam logic signed [9:0] LIM_S  = 10'(LIMIT);
    localparam logic signed [9:0] FULL_S = 10'sd360;

    logic signed [9:0] cur;
    logic signed [9:0] delta;
    logic signed [9:0] sum;
    logic signed [9:0] nxt;

    always_comb begin
        // Wrapped axes hold 0..359 unsigned; the clamped axis holds a signed value.
        cur   = (mode == MODE_WRAP) ? $signed({1'b0, angle}) : $signed({angle[8], angle});
        delta = '0;
        if (inc && !dec)
            delta = STEP_S;
        else if (dec && !inc)
            delta = -STEP_S;
        sum = cur + delta;
        nxt = sum;
        if (mode == MODE_WRAP) begin
            if (sum >= FULL_S)
                nxt = sum - FULL_S;
            else if (sum < 10'sd0)
                nxt = sum + FULL_S;
        end else begin
            if (sum > LIM_S)
                nxt = LIM_S;
            else if (sum < -LIM_S)
                nxt = -LIM_S;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            angle <= '0;
        else if (en)
            angle <= nxt[8:0];
    end

endmodule

// File: rtl/camera_pose_scheduler.sv
// Per-frame camera controller: steps pitch/yaw/roll from buttons, requests one
// basis computation, and commits the result to a frame-stable output bank.
module camera_pose_scheduler
    import camera_pkg::*;
#(
    parameter int ANGLE_STEP     = 2,
    parameter int PITCH_LIMIT    = 80,
    parameter int FRAC_BITS      = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk_100mhz,
    input  logic              rst_in,
    input  logic              frame_start_in,
    input  logic [5:0]        btn_in,
    output logic signed [8:0] pitch_out,
    output logic [8:0]        yaw_out,
    output logic [8:0]        roll_out,
    output logic              view_start_out,
    input  logic              view_done_in,
    input  vec3_t             fwd_in,
    input  vec3_t             up_in,
    input  vec3_t             right_in,
    output vec3_t             fwd_out,
    output vec3_t             up_out,
    output vec3_t             right_out,
    output logic              basis_valid_out,
    output logic              timeout_out,
    output state_t            state_out
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

    // The default fixed-point scale reuses the shared identity constants.
    localparam vec3_t RST_FWD   = (FRAC_BITS == CAM_FRAC_BITS) ? ID_FWD   : ident_vec(2, FRAC_BITS);
    localparam vec3_t RST_UP    = (FRAC_BITS == CAM_FRAC_BITS) ? ID_UP    : ident_vec(1, FRAC_BITS);
    localparam vec3_t RST_RIGHT = (FRAC_BITS == CAM_FRAC_BITS) ? ID_RIGHT : ident_vec(0, FRAC_BITS);

    state_t        state;
    logic          pending;
    logic [CW-1:0] wait_cnt;
    logic          step_en;
    logic [8:0]    pitch_q;

    assign step_en   = (state == S_STEP);
    assign pitch_out = $signed(pitch_q);
    assign state_out = state;

    angle_stepper #(.STEP(ANGLE_STEP), .LIMIT(PITCH_LIMIT)) u_pitch (
        .clk   (clk_100mhz),
        .rst   (rst_in),
        .en    (step_en),
        .inc   (btn_in[BTN_PITCH_UP]),
        .dec   (btn_in[BTN_PITCH_DOWN]),
        .mode  (MODE_CLAMP),
        .angle (pitch_q)
    );

    angle_stepper #(.STEP(ANGLE_STEP), .LIMIT(PITCH_LIMIT)) u_yaw (
        .clk   (clk_100mhz),
        .rst   (rst_in),
        .en    (step_en),
        .inc   (btn_in[BTN_YAW_RIGHT]),
        .dec   (btn_in[BTN_YAW_LEFT]),
        .mode  (MODE_WRAP),
        .angle (yaw_out)
    );

    angle_stepper #(.STEP(ANGLE_STEP), .LIMIT(PITCH_LIMIT)) u_roll (
        .clk   (clk_100mhz),
        .rst   (rst_in),
        .en    (step_en),
        .inc   (btn_in[BTN_ROLL_CW]),
        .dec   (btn_in[BTN_ROLL_CCW]),
        .mode  (MODE_WRAP),
        .angle (roll_out)
    );

    always_ff @(posedge clk_100mhz) begin
        if (rst_in) begin
            state           <= S_IDLE;
            pending         <= 1'b0;
            wait_cnt        <= '0;
            view_start_out  <= 1'b0;
            basis_valid_out <= 1'b0;
            timeout_out     <= 1'b0;
            fwd_out         <= RST_FWD;
            up_out          <= RST_UP;
            right_out       <= RST_RIGHT;
        end else begin
            view_start_out  <= 1'b0;
            basis_valid_out <= 1'b0;
            // Frames arriving while busy collapse into one deferred frame.
            if (state != S_IDLE && frame_start_in)
                pending <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (frame_start_in || pending) begin
                        state   <= S_STEP;
                        pending <= 1'b0;
                    end
                end
                S_STEP: begin
                    state          <= S_REQ;
                    view_start_out <= 1'b1;
                end
                S_REQ: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (view_done_in) begin
                        fwd_out         <= fwd_in;
                        up_out          <= up_in;
                        right_out       <= right_in;
                        basis_valid_out <= 1'b1;
                        state           <= S_COMMIT;
                    end else if (wait_cnt == LAST_WAIT) begin
                        timeout_out <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_COMMIT: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_camera_pose_scheduler.sv
// Self-checking bench for camera_pose_scheduler: directed frame sequences plus
// randomized button frames against an angle model and a basis scoreboard.
module tb_camera_pose_scheduler;
    import camera_pkg::*;

    logic              clk_100mhz = 1'b0;
    logic              rst_in = 1'b1;
    logic              frame_start_in = 1'b0;
    logic [5:0]        btn_in = '0;
    logic signed [8:0] pitch_out;
    logic [8:0]        yaw_out;
    logic [8:0]        roll_out;
    logic              view_start_out;
    logic              view_done_in = 1'b0;
    vec3_t             fwd_in = '0;
    vec3_t             up_in = '0;
    vec3_t             right_in = '0;
    vec3_t             fwd_out;
    vec3_t             up_out;
    vec3_t             right_out;
    logic              basis_valid_out;
    logic              timeout_out;
    state_t            state_out;

    camera_pose_scheduler dut (
        .clk_100mhz      (clk_100mhz),
        .rst_in          (rst_in),
        .frame_start_in  (frame_start_in),
        .btn_in          (btn_in),
        .pitch_out       (pitch_out),
        .yaw_out         (yaw_out),
        .roll_out        (roll_out),
        .view_start_out  (view_start_out),
        .view_done_in    (view_done_in),
        .fwd_in          (fwd_in),
        .up_in           (up_in),
        .right_in        (right_in),
        .fwd_out         (fwd_out),
        .up_out          (up_out),
        .right_out       (right_out),
        .basis_valid_out (basis_valid_out),
        .timeout_out     (timeout_out),
        .state_out       (state_out)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    int cyc = 0;
    always @(posedge clk_100mhz) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference angles, updated from the button rules with plain integer math.
    int m_pitch = 0;
    int m_yaw   = 0;
    int m_roll  = 0;

    function automatic int dir(input logic plus, input logic minus);
        return (plus ? 2 : 0) - (minus ? 2 : 0);
    endfunction

    task automatic model_step(input logic [5:0] b);
        m_pitch = m_pitch + dir(b[0], b[1]);
        if (m_pitch > 80)  m_pitch = 80;
        if (m_pitch < -80) m_pitch = -80;
        m_yaw  = (m_yaw  + dir(b[2], b[3]) + 360) % 360;
        m_roll = (m_roll + dir(b[4], b[5]) + 360) % 360;
    endtask

    task automatic chk_angles(input string tag);
        chk({tag, "_pitch"}, pitch_out, m_pitch);
        chk({tag, "_yaw"},   yaw_out,   m_yaw);
        chk({tag, "_roll"},  roll_out,  m_roll);
    endtask

    // Datapath model and basis scoreboard.
    logic [287:0] exp_q[$];
    logic [287:0] last_basis;
    logic [287:0] ident_basis;
    bit dp_enable = 1'b1;
    bit dp_fixed  = 1'b0;
    bit dp_drop   = 1'b0;
    int dp_lat    = 0;
    int done_cyc  = -10;
    int valid_cnt = 0;
    int start_cnt = 0;

    initial begin
        forever begin
            @(negedge clk_100mhz);
            if (view_start_out && dp_enable) begin
                int lat;
                lat = (dp_lat > 0) ? dp_lat : int'($urandom_range(1, 20));
                repeat (lat) @(negedge clk_100mhz);
                if (dp_fixed) begin
                    fwd_in   = '{x: 32'sd1, y: 32'sd2, z: 32'sd3};
                    up_in    = '{x: 32'sd4, y: 32'sd5, z: 32'sd6};
                    right_in = '{x: 32'sd7, y: 32'sd8, z: 32'sd9};
                end else begin
                    fwd_in   = '{x: $urandom, y: $urandom, z: $urandom};
                    up_in    = '{x: $urandom, y: $urandom, z: $urandom};
                    right_in = '{x: $urandom, y: $urandom, z: $urandom};
                end
                view_done_in = 1'b1;
                done_cyc = cyc;
                if (dp_drop)
                    dp_drop = 1'b0;
                else
                    exp_q.push_back({fwd_in, up_in, right_in});
                @(negedge clk_100mhz);
                view_done_in = 1'b0;
            end
        end
    end

    always @(negedge clk_100mhz) begin
        if (view_start_out) start_cnt++;
        if (basis_valid_out) begin
            valid_cnt++;
            chk("commit_expected", exp_q.size() != 0, 1);
            chk("commit_latency", cyc, done_cyc + 1);
            if (exp_q.size() != 0) begin
                last_basis = exp_q.pop_front();
                chk("commit_basis", {fwd_out, up_out, right_out}, last_basis);
            end
        end
    end

    task automatic pulse_frame(input logic [5:0] b);
        @(negedge clk_100mhz);
        btn_in = b;
        frame_start_in = 1'b1;
        @(negedge clk_100mhz);
        frame_start_in = 1'b0;
    endtask

    task automatic wait_start(output int s);
        int n;
        n = 0;
        while (!view_start_out && n < 100) begin
            @(negedge clk_100mhz);
            n++;
        end
        chk("start_seen", view_start_out, 1);
        s = cyc;
    endtask

    task automatic wait_commits(input int target, input int budget);
        int n;
        n = 0;
        while (valid_cnt < target && n < budget) begin
            @(negedge clk_100mhz);
            n++;
        end
        chk("commit_seen", valid_cnt >= target, 1);
    endtask

    task automatic run_frame(input logic [5:0] b, input string tag);
        int target;
        target = valid_cnt + 1;
        pulse_frame(b);
        model_step(b);
        wait_commits(target, 200);
        chk_angles(tag);
    endtask

    initial begin
        int s;
        int v0;
        int st0;
        logic [5:0] b;
        ident_basis = {32'sd0, 32'sd0, 32'sd65536,
                       32'sd0, 32'sd65536, 32'sd0,
                       32'sd65536, 32'sd0, 32'sd0};
        last_basis = ident_basis;

        // Reset values
        repeat (3) @(negedge clk_100mhz);
        rst_in = 1'b0;
        @(negedge clk_100mhz);
        chk_angles("reset");
        chk("reset_basis", {fwd_out, up_out, right_out}, ident_basis);
        chk("reset_timeout", timeout_out, 0);
        chk("reset_start", view_start_out, 0);
        chk("reset_valid", basis_valid_out, 0);
        chk("reset_state", state_out, 0);

        // Pitch saturation over 45 frames with a 10-cycle datapath
        dp_lat = 10;
        v0 = valid_cnt;
        for (int i = 0; i < 45; i++) begin
            run_frame(6'b000001, "pitch_up");
            chk("pitch_le_limit", $signed(pitch_out) <= 80, 1);
        end
        chk("pitch_valid_count", valid_cnt - v0, 45);
        chk("pitch_final", pitch_out, 80);

        // Wrap and opposing-button cases
        run_frame(6'b001000, "yaw_left_wrap");
        chk("yaw_is_358", yaw_out, 358);
        run_frame(6'b000100, "yaw_right_wrap");
        chk("yaw_is_0", yaw_out, 0);
        run_frame(6'b100000, "roll_ccw");
        run_frame(6'b110000, "roll_both");
        chk("roll_held_358", roll_out, 358);
        run_frame(6'b000011, "pitch_both");

        // Fixed basis words 1..9
        dp_fixed = 1'b1;
        dp_lat = 5;
        v0 = valid_cnt;
        run_frame(6'b000000, "fixed");
        chk("fixed_fwd", fwd_out, {32'sd1, 32'sd2, 32'sd3});
        chk("fixed_up", up_out, {32'sd4, 32'sd5, 32'sd6});
        chk("fixed_right", right_out, {32'sd7, 32'sd8, 32'sd9});
        @(negedge clk_100mhz);
        chk("fixed_single_valid", valid_cnt - v0, 1);
        dp_fixed = 1'b0;

        // Frames during WAIT coalesce into one extra step
        dp_lat = 30;
        v0 = valid_cnt;
        st0 = start_cnt;
        pulse_frame(6'b000100);
        model_step(6'b000100);
        wait_start(s);
        for (int i = 0; i < 3; i++) begin
            repeat (3) @(negedge clk_100mhz);
            frame_start_in = 1'b1;
            @(negedge clk_100mhz);
            frame_start_in = 1'b0;
        end
        model_step(6'b000100);
        wait_commits(v0 + 2, 300);
        repeat (80) @(negedge clk_100mhz);
        chk("coalesce_commits", valid_cnt - v0, 2);
        chk("coalesce_starts", start_cnt - st0, 2);
        chk_angles("coalesce");

        // Datapath silence: timeout after 256 wait cycles, basis kept
        dp_enable = 1'b0;
        v0 = valid_cnt;
        pulse_frame(6'b000001);
        model_step(6'b000001);
        wait_start(s);
        while (cyc < s + 255) @(negedge clk_100mhz);
        chk("timeout_not_early", timeout_out, 0);
        while (cyc < s + 258) @(negedge clk_100mhz);
        chk("timeout_set", timeout_out, 1);
        chk("timeout_basis_kept", {fwd_out, up_out, right_out}, last_basis);
        chk("timeout_no_valid", valid_cnt - v0, 0);
        chk_angles("timeout");
        dp_enable = 1'b1;
        dp_lat = 0;
        st0 = start_cnt;
        run_frame(6'b000000, "after_timeout");
        chk("after_timeout_req", start_cnt - st0, 1);
        chk("timeout_sticky", timeout_out, 1);

        // Randomized button frames
        for (int i = 0; i < 40; i++) begin
            b = 6'($urandom_range(0, 63));
            run_frame(b, "rand");
        end

        // Reset during WAIT; the late done pulse must be ignored
        dp_lat = 20;
        dp_drop = 1'b1;
        pulse_frame(6'b000101);
        wait_start(s);
        repeat (3) @(negedge clk_100mhz);
        rst_in = 1'b1;
        @(negedge clk_100mhz);
        rst_in = 1'b0;
        m_pitch = 0;
        m_yaw = 0;
        m_roll = 0;
        v0 = valid_cnt;
        repeat (40) @(negedge clk_100mhz);
        chk_angles("midreset");
        chk("midreset_basis", {fwd_out, up_out, right_out}, ident_basis);
        chk("midreset_timeout", timeout_out, 0);
        chk("midreset_no_valid", valid_cnt - v0, 0);
        chk("midreset_state", state_out, 0);
        dp_lat = 0;
        run_frame(6'b010100, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
